// File: rtl/move_ctrl_if.sv
// Move request, map RAM and tile-resolver bundle around move_ctrl.
// The master modport is the controller side; slave is everything around it.
interface move_ctrl_if;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        move_done;
  logic        moved;

  logic        map_rd_en;
  logic [7:0]  map_rd_addr;
  logic [15:0] map_rd_data;
  logic        map_wr_en;
  logic [7:0]  map_wr_addr;
  logic [15:0] map_wr_data;

  logic [15:0] res_tile_id;
  logic [3:0]  res_pos_x;
  logic [3:0]  res_pos_y;
  logic [3:0]  res_goto_x;
  logic [3:0]  res_goto_y;
  logic [3:0]  res_key_num;
  logic [7:0]  res_health;
  logic [15:0] res_new_tile;

  modport master (
    input  move_valid, move_dir, map_rd_data,
    input  res_goto_x, res_goto_y, res_key_num, res_health, res_new_tile,
    output move_ready, move_done, moved,
    output map_rd_en, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
    output res_tile_id, res_pos_x, res_pos_y
  );

  modport slave (
    output move_valid, move_dir, map_rd_data,
    output res_goto_x, res_goto_y, res_key_num, res_health, res_new_tile,
    input  move_ready, move_done, moved,
    input  map_rd_en, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
    input  res_tile_id, res_pos_x, res_pos_y
  );
endinterface

// File: rtl/move_ctrl.sv
// Player-move sequencer: reads the target tile, hands it to the resolver and
// commits the resolver's verdict to the player registers and the map.
module move_ctrl #(
  parameter logic [3:0] INIT_X      = 4'd1,
  parameter logic [3:0] INIT_Y      = 4'd1,
  parameter logic [3:0] INIT_KEYS   = 4'd0,
  parameter logic [7:0] INIT_HEALTH = 8'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  move_ctrl_if.master bus,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  key_num,
  output logic [7:0]  health
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, RESOLVE, DONE} state_t;

  state_t      state;
  logic [3:0]  tx, ty;
  logic [15:0] tile_q;
  logic        move_done_q, moved_q;
  logic        rd_en_q, wr_en_q;
  logic [7:0]  rd_addr_q, wr_addr_q;
  logic [15:0] wr_data_q;

  logic [3:0]  next_x, next_y;
  logic        off_map;

  always_comb begin
    next_x  = player_x;
    next_y  = player_y;
    off_map = 1'b0;
    case (bus.move_dir)
      2'd0: begin next_y = player_y - 4'd1; off_map = (player_y == 4'd0);  end
      2'd1: begin next_y = player_y + 4'd1; off_map = (player_y == 4'd15); end
      2'd2: begin next_x = player_x - 4'd1; off_map = (player_x == 4'd0);  end
      default: begin next_x = player_x + 4'd1; off_map = (player_x == 4'd15); end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx          <= 4'd0;
      ty          <= 4'd0;
      tile_q      <= 16'd0;
      player_x    <= INIT_X;
      player_y    <= INIT_Y;
      key_num     <= INIT_KEYS;
      health      <= INIT_HEALTH;
      move_done_q <= 1'b0;
      moved_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 16'd0;
    end else begin
      move_done_q <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.move_valid) begin
            tx <= next_x;
            ty <= next_y;
            if (off_map) begin
              moved_q     <= 1'b0;
              move_done_q <= 1'b1;
              state       <= DONE;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= {next_y, next_x};
              state     <= READ;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          tile_q <= bus.map_rd_data;
          state  <= RESOLVE;
        end
        RESOLVE: begin
          player_x    <= bus.res_goto_x;
          player_y    <= bus.res_goto_y;
          key_num     <= bus.res_key_num;
          health      <= bus.res_health;
          moved_q     <= (bus.res_goto_x != player_x) || (bus.res_goto_y != player_y);
          move_done_q <= 1'b1;
          // Only a tile the resolver actually changed goes back to the map.
          if (bus.res_new_tile != tile_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {ty, tx};
            wr_data_q <= bus.res_new_tile;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.move_ready  = (state == IDLE);
  assign bus.move_done   = move_done_q;
  assign bus.moved       = moved_q;
  assign bus.map_rd_en   = rd_en_q;
  assign bus.map_rd_addr = rd_addr_q;
  assign bus.map_wr_en   = wr_en_q;
  assign bus.map_wr_addr = wr_addr_q;
  assign bus.map_wr_data = wr_data_q;
  assign bus.res_tile_id = tile_q;
  assign bus.res_pos_x   = tx;
  assign bus.res_pos_y   = ty;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: map RAM and a small tile resolver around the DUT,
// expected move outcomes queued as each move is issued.
module tb_move_ctrl;

  localparam logic [15:0] GROUND = 16'h0001;
  localparam logic [15:0] WALL   = 16'h0002;
  localparam logic [15:0] KEY    = 16'h0003;
  localparam logic [15:0] SPIKE  = 16'h0004;

  typedef struct {
    logic [3:0]  px, py, keys;
    logic [7:0]  hp;
    logic        mv;
    int          writes;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  player_x, player_y, key_num;
  logic [7:0]  health;
  logic [15:0] mem [256];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, rd_count = 0, wr_count = 0, wr_stray = 0, done_count = 0;
  logic [7:0]  last_rd_addr = 8'd0, last_wr_addr = 8'd0;
  logic [15:0] last_wr_data = 16'd0;
  exp_t sb [$];

  move_ctrl_if mif ();

  move_ctrl u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (mif.master),
    .player_x (player_x),
    .player_y (player_y),
    .key_num  (key_num),
    .health   (health)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mif.map_rd_en) mif.map_rd_data <= mem[mif.map_rd_addr];

  // Stand-in resolver: walls block, keys are picked up, spikes hurt.
  always_comb begin
    mif.res_goto_x   = mif.res_pos_x;
    mif.res_goto_y   = mif.res_pos_y;
    mif.res_key_num  = key_num;
    mif.res_health   = health;
    mif.res_new_tile = mif.res_tile_id;
    case (mif.res_tile_id)
      WALL: begin mif.res_goto_x = player_x; mif.res_goto_y = player_y; end
      KEY: begin mif.res_key_num = key_num + 4'd1; mif.res_new_tile = GROUND; end
      SPIKE: mif.res_health = health - 8'd10;
      default: ;
    endcase
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mif.map_rd_en) begin
      rd_count     <= rd_count + 1;
      last_rd_addr <= mif.map_rd_addr;
    end
    if (mif.map_wr_en) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mif.map_wr_addr;
      last_wr_data <= mif.map_wr_data;
      if (!mif.move_done) wr_stray <= wr_stray + 1;
    end
    if (mif.move_done) done_count <= done_count + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issues one move and waits for its move_done, reporting the latency.
  task automatic applyStimulus(input logic [1:0] dir, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !mif.move_ready; i++) tick();
    mif.move_dir   = dir;
    mif.move_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.move_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (mif.move_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    vectors += 8;
    if (player_x !== 4'd1) begin miscompares++; $display("[TB] FAIL reset_x got %0d want 1", player_x); end
    if (player_y !== 4'd1) begin miscompares++; $display("[TB] FAIL reset_y got %0d want 1", player_y); end
    if (key_num !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_keys got %0d want 0", key_num); end
    if (health !== 8'd100) begin miscompares++; $display("[TB] FAIL reset_health got %0d want 100", health); end
    if (mif.move_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", mif.move_ready); end
    if (mif.map_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en got %b want 0", mif.map_rd_en); end
    if (mif.map_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en got %b want 0", mif.map_wr_en); end
    if (mif.move_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", mif.move_done); end
  endtask

  task automatic test_ground();
    int lat, rd0, wr0; bit ok; exp_t e;
    rd0 = rd_count; wr0 = wr_count;
    sb.push_back('{px:4'd2, py:4'd1, keys:4'd0, hp:8'd100, mv:1'b1, writes:0, waddr:8'h00, wdata:16'h0, lat:4});
    applyStimulus(2'd3, lat, ok);
    e = sb.pop_front();
    vectors += 7;
    if (!ok) begin miscompares++; $display("[TB] FAIL ground_done got timeout want pulse"); end
    if (lat != e.lat) begin miscompares++; $display("[TB] FAIL ground_latency got %0d want %0d", lat, e.lat); end
    if (rd_count - rd0 != 1 || last_rd_addr !== 8'h12) begin miscompares++; $display("[TB] FAIL ground_read got %0d reads addr %h want 1 at 12", rd_count - rd0, last_rd_addr); end
    if (player_x !== e.px || player_y !== e.py) begin miscompares++; $display("[TB] FAIL ground_pos got (%0d,%0d) want (%0d,%0d)", player_x, player_y, e.px, e.py); end
    if (mif.moved !== e.mv) begin miscompares++; $display("[TB] FAIL ground_moved got %b want %b", mif.moved, e.mv); end
    if (wr_count - wr0 != e.writes) begin miscompares++; $display("[TB] FAIL ground_writes got %0d want %0d", wr_count - wr0, e.writes); end
    if (mif.move_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ground_ready_in_done got %b want 0", mif.move_ready); end
  endtask

  task automatic test_key();
    int lat, wr0; bit ok; exp_t e;
    wr0 = wr_count;
    sb.push_back('{px:4'd3, py:4'd1, keys:4'd1, hp:8'd100, mv:1'b1, writes:1, waddr:8'h13, wdata:GROUND, lat:4});
    applyStimulus(2'd3, lat, ok);
    tick();
    e = sb.pop_front();
    vectors += 6;
    if (!ok) begin miscompares++; $display("[TB] FAIL key_done got timeout want pulse"); end
    if (key_num !== e.keys) begin miscompares++; $display("[TB] FAIL key_count got %0d want %0d", key_num, e.keys); end
    if (wr_count - wr0 != e.writes) begin miscompares++; $display("[TB] FAIL key_writes got %0d want %0d", wr_count - wr0, e.writes); end
    if (last_wr_addr !== e.waddr) begin miscompares++; $display("[TB] FAIL key_wr_addr got %h want %h", last_wr_addr, e.waddr); end
    if (last_wr_data !== e.wdata) begin miscompares++; $display("[TB] FAIL key_wr_data got %h want %h", last_wr_data, e.wdata); end
    if (wr_stray != 0) begin miscompares++; $display("[TB] FAIL key_wr_outside_done got %0d want 0", wr_stray); end
  endtask

  task automatic test_wall();
    int lat, rd0, wr0; bit ok; exp_t e;
    rd0 = rd_count; wr0 = wr_count;
    sb.push_back('{px:4'd3, py:4'd1, keys:4'd1, hp:8'd100, mv:1'b0, writes:0, waddr:8'h00, wdata:16'h0, lat:4});
    applyStimulus(2'd0, lat, ok);
    e = sb.pop_front();
    vectors += 5;
    if (!ok) begin miscompares++; $display("[TB] FAIL wall_done got timeout want pulse"); end
    if (last_rd_addr !== 8'h03 || rd_count - rd0 != 1) begin miscompares++; $display("[TB] FAIL wall_read got addr %h want 03", last_rd_addr); end
    if (player_x !== e.px || player_y !== e.py) begin miscompares++; $display("[TB] FAIL wall_pos got (%0d,%0d) want (%0d,%0d)", player_x, player_y, e.px, e.py); end
    if (mif.moved !== e.mv) begin miscompares++; $display("[TB] FAIL wall_moved got %b want %b", mif.moved, e.mv); end
    if (wr_count - wr0 != e.writes) begin miscompares++; $display("[TB] FAIL wall_writes got %0d want %0d", wr_count - wr0, e.writes); end
  endtask

  task automatic test_spike();
    int lat, wr0; bit ok; exp_t e;
    wr0 = wr_count;
    sb.push_back('{px:4'd3, py:4'd2, keys:4'd1, hp:8'd90, mv:1'b1, writes:0, waddr:8'h00, wdata:16'h0, lat:4});
    applyStimulus(2'd1, lat, ok);
    e = sb.pop_front();
    vectors += 4;
    if (!ok) begin miscompares++; $display("[TB] FAIL spike_done got timeout want pulse"); end
    if (health !== e.hp) begin miscompares++; $display("[TB] FAIL spike_health got %0d want %0d", health, e.hp); end
    if (player_y !== e.py) begin miscompares++; $display("[TB] FAIL spike_y got %0d want %0d", player_y, e.py); end
    if (wr_count - wr0 != e.writes) begin miscompares++; $display("[TB] FAIL spike_writes got %0d want %0d", wr_count - wr0, e.writes); end
  endtask

  // Request held high: one move every 5 cycles, walking left to x=0.
  task automatic test_back_to_back();
    int stamps [$]; exp_t e;
    for (int k = 0; k < 3; k++)
      sb.push_back('{px:4'(2 - k), py:4'd2, keys:4'd1, hp:8'd90, mv:1'b1, writes:0, waddr:8'h00, wdata:16'h0, lat:4});
    mif.move_dir   = 2'd2;
    mif.move_valid = 1'b1;
    for (int i = 0; i < 40 && stamps.size() < 3; i++) begin
      tick();
      if (mif.move_done) begin
        stamps.push_back(cyc);
        e = sb.pop_front();
        vectors++;
        if (player_x !== e.px) begin miscompares++; $display("[TB] FAIL b2b_x got %0d want %0d", player_x, e.px); end
      end
    end
    mif.move_valid = 1'b0;
    vectors++;
    if (stamps.size() != 3) begin
      miscompares++; $display("[TB] FAIL b2b_count got %0d want 3", stamps.size());
    end else begin
      vectors++;
      if (stamps[1] - stamps[0] != 5 || stamps[2] - stamps[1] != 5) begin
        miscompares++; $display("[TB] FAIL b2b_spacing got %0d,%0d want 5,5", stamps[1] - stamps[0], stamps[2] - stamps[1]);
      end
    end
  endtask

  task automatic test_off_map();
    int lat, rd0; bit ok;
    rd0 = rd_count;
    applyStimulus(2'd2, lat, ok);
    vectors += 5;
    if (!ok || lat != 1) begin miscompares++; $display("[TB] FAIL offmap_latency got %0d want 1", lat); end
    if (mif.moved !== 1'b0) begin miscompares++; $display("[TB] FAIL offmap_moved got %b want 0", mif.moved); end
    if (player_x !== 4'd0) begin miscompares++; $display("[TB] FAIL offmap_x got %0d want 0", player_x); end
    tick();
    if (rd_count != rd0) begin miscompares++; $display("[TB] FAIL offmap_reads got %0d want 0", rd_count - rd0); end
    if (mif.move_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL offmap_ready got %b want 1", mif.move_ready); end
  endtask

  task automatic test_reset_abort();
    int done0, wr0;
    for (int i = 0; i < 20 && !mif.move_ready; i++) tick();
    mif.move_dir   = 2'd3;
    mif.move_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.move_valid = 1'b0;
    tick();
    tick();
    done0 = done_count; wr0 = wr_count;
    rst_n = 1'b0;
    #1;
    vectors += 6;
    if (player_x !== 4'd1 || player_y !== 4'd1) begin miscompares++; $display("[TB] FAIL abort_pos got (%0d,%0d) want (1,1)", player_x, player_y); end
    if (key_num !== 4'd0 || health !== 8'd100) begin miscompares++; $display("[TB] FAIL abort_state got keys %0d hp %0d want 0 100", key_num, health); end
    if (mif.move_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready got %b want 1", mif.move_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    if (done_count != done0) begin miscompares++; $display("[TB] FAIL abort_done got %0d pulses want 0", done_count - done0); end
    if (wr_count != wr0) begin miscompares++; $display("[TB] FAIL abort_writes got %0d want 0", wr_count - wr0); end
    if (player_x !== 4'd1) begin miscompares++; $display("[TB] FAIL abort_hold_x got %0d want 1", player_x); end
  endtask

  task automatic test_held_request();
    int done0, rd0;
    done0 = done_count; rd0 = rd_count;
    mif.move_dir   = 2'd3;
    mif.move_valid = 1'b1;
    vectors += 5;
    tick();
    tick();
    tick();
    if (mif.move_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL held_ready_resolve got %b want 0", mif.move_ready); end
    tick();
    if (mif.move_done !== 1'b1) begin miscompares++; $display("[TB] FAIL held_done got %b want 1", mif.move_done); end
    mif.move_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    if (done_count - done0 != 1) begin miscompares++; $display("[TB] FAIL held_moves got %0d want 1", done_count - done0); end
    if (rd_count - rd0 != 1) begin miscompares++; $display("[TB] FAIL held_reads got %0d want 1", rd_count - rd0); end
    if (player_x !== 4'd2) begin miscompares++; $display("[TB] FAIL held_x got %0d want 2", player_x); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = GROUND;
    mem[8'h13] = KEY;
    mem[8'h03] = WALL;
    mem[8'h23] = SPIKE;
    mif.move_valid  = 1'b0;
    mif.move_dir    = 2'd0;
    mif.map_rd_data = 16'h0;
    rst_n = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_ground();
    test_key();
    test_wall();
    test_spike();
    test_back_to_back();
    test_off_map();
    test_reset_abort();
    test_held_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
